db_buffer_ctrl: RTL and testbench
=================================

Name: db_buffer_ctrl

Overview:
- Controller and arbiter for the 64-byte data buffer RAM (db_fifo) inside the data buffer.
- Arbitrates two writers: the USB RX byte store and the AHB host store. Arbitrates two readers: the USB TX byte fetch and the AHB host fetch.
- Owns the write/read pointers, sequences the RAM's two-phase read (get_* one cycle before read_en), and reports occupancy, full/empty and overflow/underflow.

Parameters:
- DEPTH, 64, buffer entries; must equal the RAM depth.
- PTR_W, 7, pointer/occupancy width; holds the range 0..DEPTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  host clear request (level, sampled each cycle).
- flush  in  1  protocol flush request (level).
- rx_store_req  in  1  USB RX byte write request; held until ack.
- rx_store_data  in  8  USB RX byte.
- ahb_store_req  in  1  AHB byte write request; held until ack.
- ahb_store_data  in  8  AHB byte.
- tx_get_req  in  1  USB TX byte read request; held until ack.
- ahb_get_req  in  1  AHB byte read request; held until ack.
- rx_store_ack, ahb_store_ack, tx_get_ack, ahb_get_ack  out  1 each  one-cycle acceptance pulses.
- tx_data_valid, ahb_data_valid  out  1 each  pulse; RAM output register holds the popped byte.
- err_overflow, err_underflow  out  1 each  one-cycle error pulses.
- write_en  out  1  to RAM.
- write_data  out  8  to RAM.
- write_ptr  out  PTR_W  to RAM.
- read_en  out  1  to RAM.
- read_ptr  out  PTR_W  to RAM.
- get_tx_data, get_rx_data  out  1 each  to RAM.
- ram_clear  out  1  to RAM clear input.
- occupancy  out  PTR_W  wr_cnt - rd_cnt.
- full, empty  out  1 each  status flags.

Behaviour:
- Internal counters wr_cnt and rd_cnt (PTR_W bits) wrap modulo 2^PTR_W. occupancy = wr_cnt - rd_cnt, PTR_W-bit wrap subtraction, range 0..64. full = (occupancy == DEPTH); empty = (occupancy == 0).
- RAM addressing contract: the RAM writes and reads entry [ptr-1]. write_ptr = wr_cnt+1 while write_en is high, else wr_cnt. read_ptr = rd_cnt+1 while read_en is high, else rd_cnt.
- Reset (rst=1 at a clk edge): FSM goes to IDLE; counters = 0. All acks, valids, errors, write_en, read_en and get_* are 0. write_data = 0. ram_clear = 1 during reset, otherwise ram_clear = clear|flush. occupancy = 0, empty = 1, full = 0.
- FSM states IDLE, RD_ARM, RD_POP. A latched reader-select bit is_tx records which reader is being served.
- IDLE, arbitration (fixed priority): rx_store > ahb_store > tx_get > ahb_get. Only one grant per cycle.
- Write grant: same cycle, combinational: ack=1, write_en=1, write_data = the selected writer's byte; wr_cnt+1 at the edge. If full: ack=1, err_overflow=1, write_en=0, counters unchanged. The state stays IDLE, so back-to-back writes run at 1 byte/cycle.
- Read grant: ack=1 and the FSM goes to RD_ARM, with is_tx latched. If empty: ack=1, err_underflow=1, no state change, no RAM activity.
- RD_ARM: get_tx_data = is_tx, get_rx_data = !is_tx, for one cycle; next state RD_POP.
- RD_POP: read_en=1, read_ptr = rd_cnt+1; rd_cnt+1 at the edge; next state IDLE.
- Valid pulse: in the cycle after RD_POP, tx_data_valid (is_tx) or ahb_data_valid (!is_tx) pulses.
- Read throughput: 1 byte per 3 cycles. The valid cycle coincides with IDLE, so a new grant may be issued in that same cycle.
- Writes requested during RD_ARM or RD_POP are not acked; the request is held and served in IDLE.
- clear or flush in any state has priority over everything in that cycle:
  - no acks are issued;
  - write_en = read_en = get_* = 0;
  - counters go to 0 at the edge and the FSM goes to IDLE;
  - a pending valid pulse is suppressed;
  - err_* = 0.
- Counter wrap: after 128 writes/reads wr_cnt wraps to 0; occupancy stays correct.
- Simultaneous write-full and read request: the write has priority, so overflow is flagged and the read waits.

Decomposition:
- Package db_pkg:
  - DEPTH and PTR_W constants;
  - typedef enum logic [1:0] {IDLE, RD_ARM, RD_POP} db_ctrl_state_t;
  - typedef enum logic [1:0] grant_t {G_NONE, G_RX_ST, G_AHB_ST, G_RD}.
- Sub-module db_req_arb: combinational fixed-priority arbiter producing grant_t and the reader select. Instantiated once.

Test Plan:
1. Reset, then 3 rx_store bytes 0xA1, 0xA2, 0xA3 back-to-back: 3 acks on consecutive cycles, write_ptr 1,2,3 with write_en, occupancy = 3.
2. Then tx_get_req: ack, then get_tx_data on cycle +1, read_en with read_ptr = 1 on cycle +2, tx_data_valid on cycle +3 with RAM output 0xA1; occupancy = 2.
3. Fill with 64 ahb_store writes, then one more: full = 1; 65th ack carries err_overflow = 1 and write_en = 0; occupancy stays 64.
4. From empty, ahb_get_req: ack with err_underflow = 1, no get_rx_data and no read_en, state stays IDLE.
5. rx_store_req and tx_get_req asserted together with occupancy = 5: rx is acked first (occupancy 6), tx is acked the next cycle.
6. flush asserted during RD_POP with occupancy = 10: no valid pulse, ram_clear = 1, occupancy = 0 the next cycle, state IDLE. Repeat the run with 130 write/read pairs to check wrap, with occupancy correct throughout.

Source files
------------

// File: rtl/db_pkg.sv
// Shared constants and types for the data buffer controller.
package db_pkg;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned PTR_W  = 7;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ARM = 2'd1,
        RD_POP = 2'd2
    } db_ctrl_state_t;

    typedef enum logic [1:0] {
        G_NONE   = 2'd0,
        G_RX_ST  = 2'd1,
        G_AHB_ST = 2'd2,
        G_RD     = 2'd3
    } grant_t;

endpackage

// File: rtl/db_req_arb.sv
// Fixed-priority request arbiter: rx_store > ahb_store > tx_get > ahb_get.
module db_req_arb
    import db_pkg::*;
(
    input  logic       rx_store_req,
    input  logic       ahb_store_req,
    input  logic       tx_get_req,
    input  logic       ahb_get_req,
    output logic [1:0] grant,
    output logic       rd_is_tx
);

    // One grant per cycle; writers always beat readers.
    always_comb begin
        grant    = G_NONE;
        rd_is_tx = 1'b0;
        if (rx_store_req) begin
            grant = G_RX_ST;
        end else if (ahb_store_req) begin
            grant = G_AHB_ST;
        end else if (tx_get_req) begin
            grant    = G_RD;
            rd_is_tx = 1'b1;
        end else if (ahb_get_req) begin
            grant = G_RD;
        end
    end

endmodule

// File: rtl/db_buffer_ctrl.sv
// Data buffer RAM controller: arbitrates two writers and two readers,
// owns the wrap-around counters and sequences the two-phase RAM read.
module db_buffer_ctrl
    import db_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              flush,
    input  logic              rx_store_req,
    input  logic [DATA_W-1:0] rx_store_data,
    input  logic              ahb_store_req,
    input  logic [DATA_W-1:0] ahb_store_data,
    input  logic              tx_get_req,
    input  logic              ahb_get_req,
    output logic              rx_store_ack,
    output logic              ahb_store_ack,
    output logic              tx_get_ack,
    output logic              ahb_get_ack,
    output logic              tx_data_valid,
    output logic              ahb_data_valid,
    output logic              err_overflow,
    output logic              err_underflow,
    output logic              write_en,
    output logic [DATA_W-1:0] write_data,
    output logic [PTR_W-1:0]  write_ptr,
    output logic              read_en,
    output logic [PTR_W-1:0]  read_ptr,
    output logic              get_tx_data,
    output logic              get_rx_data,
    output logic              ram_clear,
    output logic [PTR_W-1:0]  occupancy,
    output logic              full,
    output logic              empty
);

    db_ctrl_state_t   state_q, state_d;
    logic             is_tx_q, is_tx_d;
    logic [PTR_W-1:0] wr_cnt_q, rd_cnt_q;
    logic             valid_q;
    logic             kill;
    logic [1:0]       arb_grant;
    logic             arb_is_tx;
    grant_t           grant;

    // clear/flush (and reset) override every other activity in the cycle
    assign kill      = rst | clear | flush;
    assign ram_clear = kill;

    db_req_arb u_arb (
        .rx_store_req  (rx_store_req),
        .ahb_store_req (ahb_store_req),
        .tx_get_req    (tx_get_req),
        .ahb_get_req   (ahb_get_req),
        .grant         (arb_grant),
        .rd_is_tx      (arb_is_tx)
    );

    assign grant = grant_t'(arb_grant);

    // Occupancy by modular subtraction; counters span 0..2*DEPTH-1
    assign occupancy = wr_cnt_q - rd_cnt_q;
    assign full      = (occupancy == PTR_W'(DEPTH));
    assign empty     = (occupancy == '0);

    // RAM acts on entry [ptr-1], so the pointer leads the counter while enabled
    assign write_ptr = wr_cnt_q + PTR_W'(write_en);
    assign read_ptr  = rd_cnt_q + PTR_W'(read_en);

    // Valid pulses in the cycle after the pop, unless killed in that cycle
    assign tx_data_valid  = valid_q &  is_tx_q & ~kill;
    assign ahb_data_valid = valid_q & ~is_tx_q & ~kill;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            is_tx_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_tx_q <= is_tx_d;
        end
    end

    // Next-state, grant handshakes and RAM strobes
    always_comb begin
        state_d       = state_q;
        is_tx_d       = is_tx_q;
        rx_store_ack  = 1'b0;
        ahb_store_ack = 1'b0;
        tx_get_ack    = 1'b0;
        ahb_get_ack   = 1'b0;
        err_overflow  = 1'b0;
        err_underflow = 1'b0;
        write_en      = 1'b0;
        write_data    = '0;
        read_en       = 1'b0;
        get_tx_data   = 1'b0;
        get_rx_data   = 1'b0;

        if (kill) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    case (grant)
                        G_RX_ST: begin
                            rx_store_ack = 1'b1;
                            if (full) begin
                                err_overflow = 1'b1;
                            end else begin
                                write_en   = 1'b1;
                                write_data = rx_store_data;
                            end
                        end
                        G_AHB_ST: begin
                            ahb_store_ack = 1'b1;
                            if (full) begin
                                err_overflow = 1'b1;
                            end else begin
                                write_en   = 1'b1;
                                write_data = ahb_store_data;
                            end
                        end
                        G_RD: begin
                            tx_get_ack  = arb_is_tx;
                            ahb_get_ack = ~arb_is_tx;
                            if (empty) begin
                                err_underflow = 1'b1;
                            end else begin
                                state_d = RD_ARM;
                                is_tx_d = arb_is_tx;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
                RD_ARM: begin
                    get_tx_data = is_tx_q;
                    get_rx_data = ~is_tx_q;
                    state_d     = RD_POP;
                end
                RD_POP: begin
                    read_en = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Pointer counters and the one-cycle pop-to-valid delay
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            valid_q  <= 1'b0;
        end else if (kill) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_q + PTR_W'(write_en);
            rd_cnt_q <= rd_cnt_q + PTR_W'(read_en);
            valid_q  <= read_en;
        end
    end

endmodule

// File: tb/tb_db_buffer_ctrl.sv
// Self-checking bench for db_buffer_ctrl with a queue-based buffer model.
module tb_db_buffer_ctrl;

    logic       clk = 1'b0;
    logic       rst, clear, flush;
    logic       rx_store_req, ahb_store_req, tx_get_req, ahb_get_req;
    logic [7:0] rx_store_data, ahb_store_data;
    logic       rx_store_ack, ahb_store_ack, tx_get_ack, ahb_get_ack;
    logic       tx_data_valid, ahb_data_valid, err_overflow, err_underflow;
    logic       write_en, read_en, get_tx_data, get_rx_data, ram_clear;
    logic [7:0] write_data;
    logic [6:0] write_ptr, read_ptr, occupancy;
    logic       full, empty;

    int checks = 0;
    int passes = 0;

    // Reference model: FIFO contents and transfer counts since last clear
    logic [7:0] q[$];
    int         wr_total = 0;
    int         rd_total = 0;

    // Behavioural RAM: writes/reads entry [ptr-1], registered read output
    logic [7:0] mem [64];
    logic [7:0] ram_dout;

    always #5 clk = ~clk;

    db_buffer_ctrl dut (
        .clk(clk), .rst(rst), .clear(clear), .flush(flush),
        .rx_store_req(rx_store_req), .rx_store_data(rx_store_data),
        .ahb_store_req(ahb_store_req), .ahb_store_data(ahb_store_data),
        .tx_get_req(tx_get_req), .ahb_get_req(ahb_get_req),
        .rx_store_ack(rx_store_ack), .ahb_store_ack(ahb_store_ack),
        .tx_get_ack(tx_get_ack), .ahb_get_ack(ahb_get_ack),
        .tx_data_valid(tx_data_valid), .ahb_data_valid(ahb_data_valid),
        .err_overflow(err_overflow), .err_underflow(err_underflow),
        .write_en(write_en), .write_data(write_data), .write_ptr(write_ptr),
        .read_en(read_en), .read_ptr(read_ptr),
        .get_tx_data(get_tx_data), .get_rx_data(get_rx_data),
        .ram_clear(ram_clear), .occupancy(occupancy), .full(full), .empty(empty)
    );

    always @(posedge clk) begin
        if (ram_clear) begin
            ram_dout <= 8'h00;
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
        end else begin
            if (write_en) mem[6'(write_ptr - 7'd1)] <= write_data;
            if (read_en)  ram_dout <= mem[6'(read_ptr - 7'd1)];
        end
    end

    task automatic model_clear();
        q.delete();
        wr_total = 0;
        rd_total = 0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if ({ram_clear, rx_store_ack, ahb_store_ack, write_en, read_en} !== 5'b10000)
            $display("FAIL flush_cycle: got %b exp 10000",
                     {ram_clear, rx_store_ack, ahb_store_ack, write_en, read_en});
        else passes++;
        @(posedge clk); #1;
        flush = 1'b0;
        model_clear();
    endtask

    task automatic do_write(input bit use_ahb, input logic [7:0] d, input string tag);
        logic ack_s, ack_o;
        bit   exp_full;
        if (use_ahb) begin ahb_store_req = 1'b1; ahb_store_data = d; end
        else begin rx_store_req = 1'b1; rx_store_data = d; end
        @(negedge clk);
        exp_full = (q.size() == 64);
        ack_s = use_ahb ? ahb_store_ack : rx_store_ack;
        ack_o = use_ahb ? rx_store_ack  : ahb_store_ack;
        checks++;
        if ({ack_s, ack_o, err_overflow, write_en} !== {1'b1, 1'b0, exp_full, !exp_full})
            $display("FAIL %s wr_handshake: got %b exp %b", tag,
                     {ack_s, ack_o, err_overflow, write_en}, {1'b1, 1'b0, exp_full, !exp_full});
        else passes++;
        if (!exp_full) begin
            checks++;
            if ({write_ptr, write_data} !== {7'(wr_total + 1), d})
                $display("FAIL %s wr_ptr_data: got %h/%h exp %h/%h", tag,
                         write_ptr, write_data, 7'(wr_total + 1), d);
            else passes++;
        end
        checks++;
        if ({occupancy, full} !== {7'(q.size()), exp_full})
            $display("FAIL %s wr_occ: got %0d/%b exp %0d/%b", tag, occupancy, full, q.size(), exp_full);
        else passes++;
        @(posedge clk); #1;
        rx_store_req = 1'b0; ahb_store_req = 1'b0;
        if (!exp_full) begin q.push_back(d); wr_total++; end
    endtask

    // Full read sequence; optionally holds a write request across the read
    task automatic do_read(input bit is_tx, input bit hold_wr, input string tag);
        bit         exp_empty;
        logic [7:0] exp_byte, wd;
        if (is_tx) tx_get_req = 1'b1; else ahb_get_req = 1'b1;
        @(negedge clk);
        exp_empty = (q.size() == 0);
        checks++;
        if ({tx_get_ack, ahb_get_ack, err_underflow, write_en, read_en} !==
            {is_tx, !is_tx, exp_empty, 1'b0, 1'b0})
            $display("FAIL %s rd_grant: got %b exp %b", tag,
                     {tx_get_ack, ahb_get_ack, err_underflow, write_en, read_en},
                     {is_tx, !is_tx, exp_empty, 1'b0, 1'b0});
        else passes++;
        @(posedge clk); #1;
        tx_get_req = 1'b0; ahb_get_req = 1'b0;
        if (exp_empty) begin
            @(negedge clk);
            checks++;
            if ({get_tx_data, get_rx_data, read_en} !== 3'b000)
                $display("FAIL %s underflow_quiet: got %b exp 000", tag,
                         {get_tx_data, get_rx_data, read_en});
            else passes++;
            @(posedge clk); #1;
            return;
        end
        wd = 8'($urandom);
        if (hold_wr) begin rx_store_req = 1'b1; rx_store_data = wd; end
        @(negedge clk);
        checks++;
        if ({get_tx_data, get_rx_data, read_en, rx_store_ack, write_en} !==
            {is_tx, !is_tx, 1'b0, 1'b0, 1'b0})
            $display("FAIL %s rd_arm: got %b exp %b", tag,
                     {get_tx_data, get_rx_data, read_en, rx_store_ack, write_en},
                     {is_tx, !is_tx, 1'b0, 1'b0, 1'b0});
        else passes++;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({read_en, read_ptr, get_tx_data, get_rx_data, rx_store_ack} !==
            {1'b1, 7'(rd_total + 1), 1'b0, 1'b0, 1'b0})
            $display("FAIL %s rd_pop: got %b exp %b", tag,
                     {read_en, read_ptr, get_tx_data, get_rx_data, rx_store_ack},
                     {1'b1, 7'(rd_total + 1), 1'b0, 1'b0, 1'b0});
        else passes++;
        @(posedge clk); #1;
        exp_byte = q.pop_front();
        rd_total++;
        @(negedge clk);
        checks++;
        if ({tx_data_valid, ahb_data_valid, ram_dout, occupancy} !==
            {is_tx, !is_tx, exp_byte, 7'(q.size())})
            $display("FAIL %s rd_valid: got %b/%h/%0d exp %b/%h/%0d", tag,
                     {tx_data_valid, ahb_data_valid}, ram_dout, occupancy,
                     {is_tx, !is_tx}, exp_byte, q.size());
        else passes++;
        if (hold_wr) begin
            checks++;
            if ({rx_store_ack, write_en, write_ptr} !== {1'b1, 1'b1, 7'(wr_total + 1)})
                $display("FAIL %s held_write: got %b exp %b", tag,
                         {rx_store_ack, write_en, write_ptr}, {1'b1, 1'b1, 7'(wr_total + 1)});
            else passes++;
        end
        @(posedge clk); #1;
        if (hold_wr) begin
            rx_store_req = 1'b0;
            q.push_back(wd);
            wr_total++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({ram_clear, occupancy, empty, full, write_en, read_en, rx_store_ack, tx_data_valid} !==
            {1'b1, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_hold: got %b", {ram_clear, occupancy, empty, full,
                     write_en, read_en, rx_store_ack, tx_data_valid});
        else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        checks++;
        if ({ram_clear, occupancy, empty, full} !== {1'b0, 7'd0, 1'b1, 1'b0})
            $display("FAIL reset_release: got %b exp 0_0000000_1_0",
                     {ram_clear, occupancy, empty, full});
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_rx_burst_and_tx_read();
        do_write(1'b0, 8'hA1, "burst0");
        do_write(1'b0, 8'hA2, "burst1");
        do_write(1'b0, 8'hA3, "burst2");
        do_read(1'b1, 1'b0, "first_read");
    endtask

    task automatic test_fill_overflow();
        do_flush();
        for (int i = 0; i < 65; i++) do_write(1'b1, 8'($urandom), "fill");
        // Full write and pending read together: write wins, read not acked
        ahb_store_req = 1'b1; tx_get_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({ahb_store_ack, err_overflow, write_en, tx_get_ack, occupancy} !==
            {1'b1, 1'b1, 1'b0, 1'b0, 7'd64})
            $display("FAIL full_vs_read: got %b", {ahb_store_ack, err_overflow,
                     write_en, tx_get_ack, occupancy});
        else passes++;
        @(posedge clk); #1;
        ahb_store_req = 1'b0;
        do_read(1'b1, 1'b0, "read_after_full");
        do_read(1'b0, 1'b0, "ahb_read_after_full");
    endtask

    task automatic test_underflow();
        do_flush();
        do_read(1'b0, 1'b0, "underflow_ahb");
        do_read(1'b1, 1'b0, "underflow_tx");
        do_write(1'b0, 8'h5C, "after_underflow");
    endtask

    task automatic test_priority();
        do_flush();
        for (int i = 0; i < 5; i++) do_write(1'b0, 8'(8'h10 + i), "prio_fill");
        rx_store_req = 1'b1; rx_store_data = 8'h77; tx_get_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({rx_store_ack, tx_get_ack, write_en, occupancy} !== {1'b1, 1'b0, 1'b1, 7'd5})
            $display("FAIL prio_rx_first: got %b exp 1_0_1_0000101",
                     {rx_store_ack, tx_get_ack, write_en, occupancy});
        else passes++;
        @(posedge clk); #1;
        rx_store_req = 1'b0;
        q.push_back(8'h77); wr_total++;
        do_read(1'b1, 1'b0, "prio_tx_second");
    endtask

    task automatic test_flush_during_pop();
        do_flush();
        for (int i = 0; i < 10; i++) do_write(1'b1, 8'($urandom), "fl_fill");
        tx_get_req = 1'b1;
        @(posedge clk); #1;
        tx_get_req = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if ({read_en, ram_clear, tx_get_ack, get_tx_data, err_underflow} !== 5'b01000)
            $display("FAIL flush_pop: got %b exp 01000",
                     {read_en, ram_clear, tx_get_ack, get_tx_data, err_underflow});
        else passes++;
        @(posedge clk); #1;
        flush = 1'b0;
        model_clear();
        @(negedge clk);
        checks++;
        if ({tx_data_valid, ahb_data_valid, occupancy, empty} !== {1'b0, 1'b0, 7'd0, 1'b1})
            $display("FAIL flush_after: got %b exp 0_0_0000000_1",
                     {tx_data_valid, ahb_data_valid, occupancy, empty});
        else passes++;
        @(posedge clk); #1;
        do_write(1'b0, 8'h3E, "post_flush_idle");
    endtask

    task automatic test_wrap_random();
        do_flush();
        for (int i = 0; i < 130; i++) begin
            do_write(1'($urandom), 8'($urandom), "wrap_wr");
            do_read(1'($urandom), ($urandom_range(0, 3) == 0), "wrap_rd");
        end
        checks++;
        if ({occupancy, empty} !== {7'(q.size()), q.size() == 0})
            $display("FAIL wrap_final_occ: got %0d exp %0d", occupancy, q.size());
        else passes++;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; flush = 1'b0;
        rx_store_req = 1'b0; ahb_store_req = 1'b0;
        tx_get_req = 1'b0; ahb_get_req = 1'b0;
        rx_store_data = 8'h00; ahb_store_data = 8'h00;
        test_reset();
        test_rx_burst_and_tx_read();
        test_fill_overflow();
        test_underflow();
        test_priority();
        test_flush_during_pop();
        test_wrap_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
